// File: rtl/sc_failmonitor_multi.sv
// N-channel comparator fail monitor: per-channel debounce, latched flags, popcount and total-fail FSM.
// Optional macro SC_FAILMONITOR_FIRSTFAIL_EN adds first-failed-channel capture outputs.
module sc_failmonitor_multi #(
  parameter int NUM_CH    = 4,
  parameter int IDX_W     = 2,
  parameter int DEBOUNCE  = 3,
  parameter int THRESHOLD = 2
) (
  input  logic              SC_FAILMONITOR_CLOCK_50,
  input  logic              SC_FAILMONITOR_RESET_InLow,
  input  logic [NUM_CH-1:0] SC_FAILMONITOR_Comparador_CFAIL_InLow,
  input  logic              SC_FAILMONITOR_startButton_InLow,
  output logic [NUM_CH-1:0] SC_FAILMONITOR_FAIL_Out,
  output logic [IDX_W:0]    SC_FAILMONITOR_FAILCOUNT_Out,
  output logic              SC_FAILMONITOR_TOTAL_FAIL_Out,
  output logic              SC_FAILMONITOR_ARMED_Out
`ifdef SC_FAILMONITOR_FIRSTFAIL_EN
  ,
  output logic [IDX_W-1:0]  SC_FAILMONITOR_FIRSTFAIL_Out,
  output logic              SC_FAILMONITOR_FIRSTVALID_Out
`endif
);

  localparam int CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [IDX_W:0]   THR     = (IDX_W + 1)'(THRESHOLD);

  typedef enum logic [2:0] {
    RESET_0 = 3'd0,
    START_0 = 3'd1,
    CHECK_0 = 3'd2,
    FAULT_0 = 3'd3,
    INIT_0  = 3'd4,
    CHECK_1 = 3'd5,
    TOTAL_0 = 3'd6
  } state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_db [NUM_CH];
  logic [NUM_CH-1:0] r_fail, w_run, w_qual, w_fail_next;
  logic [IDX_W:0]    r_count, w_count_next;
  logic              w_monitor, w_start;

  always_comb begin
    w_monitor = (r_state == CHECK_0) || (r_state == FAULT_0);
    w_start   = !SC_FAILMONITOR_startButton_InLow;
    w_run     = '0;
    w_qual    = '0;
    // A press on the qualifying edge wins: counters stop and the qualification is dropped.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_run[i]  = w_monitor && !w_start && !r_fail[i] && !SC_FAILMONITOR_Comparador_CFAIL_InLow[i];
      w_qual[i] = w_run[i] && (r_db[i] == DB_LAST);
    end
    w_fail_next  = r_fail | w_qual;
    w_count_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      w_count_next = w_count_next + (IDX_W + 1)'(w_fail_next[i]);

    w_state_next = r_state;
    case (r_state)
      RESET_0: w_state_next = START_0;
      START_0: w_state_next = CHECK_0;
      CHECK_0, FAULT_0: begin
        if (w_start)                   w_state_next = INIT_0;
        else if (w_count_next >= THR)  w_state_next = TOTAL_0;
        else if (w_count_next != '0)   w_state_next = FAULT_0;
        else                           w_state_next = CHECK_0;
      end
      INIT_0:  w_state_next = CHECK_1;
      CHECK_1: w_state_next = w_start ? CHECK_1 : CHECK_0;
      TOTAL_0: w_state_next = TOTAL_0;
      default: w_state_next = RESET_0;
    endcase
  end

  always_ff @(posedge SC_FAILMONITOR_CLOCK_50 or negedge SC_FAILMONITOR_RESET_InLow) begin
    if (!SC_FAILMONITOR_RESET_InLow) begin
      r_state <= RESET_0;
      r_fail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_db[i] <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == INIT_0) begin
        r_fail  <= '0;
        r_count <= '0;
      end else if (w_monitor) begin
        r_fail  <= w_fail_next;
        r_count <= w_count_next;
      end
      for (int unsigned i = 0; i < NUM_CH; i++)
        r_db[i] <= (w_run[i] && !w_qual[i]) ? r_db[i] + 1'b1 : '0;
    end
  end

  assign SC_FAILMONITOR_FAIL_Out       = r_fail;
  assign SC_FAILMONITOR_FAILCOUNT_Out  = r_count;
  assign SC_FAILMONITOR_TOTAL_FAIL_Out = (r_state == TOTAL_0);
  assign SC_FAILMONITOR_ARMED_Out      = (r_state == CHECK_0) || (r_state == FAULT_0);

`ifdef SC_FAILMONITOR_FIRSTFAIL_EN
  logic [IDX_W-1:0] r_first_idx, w_low_idx;
  logic             r_first_valid, w_found;

  always_comb begin
    w_low_idx = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_qual[i] && !w_found) begin
        w_low_idx = IDX_W'(i);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge SC_FAILMONITOR_CLOCK_50 or negedge SC_FAILMONITOR_RESET_InLow) begin
    if (!SC_FAILMONITOR_RESET_InLow) begin
      r_first_idx   <= '0;
      r_first_valid <= 1'b0;
    end else if (r_state == INIT_0) begin
      r_first_idx   <= '0;
      r_first_valid <= 1'b0;
    end else if (!r_first_valid && w_found) begin
      r_first_idx   <= w_low_idx;
      r_first_valid <= 1'b1;
    end
  end

  assign SC_FAILMONITOR_FIRSTFAIL_Out  = r_first_idx;
  assign SC_FAILMONITOR_FIRSTVALID_Out = r_first_valid;
`endif

endmodule

// File: tb/tb_sc_failmonitor_multi.sv
// Directed, table-driven bench for sc_failmonitor_multi (NUM_CH=4, DEBOUNCE=3, THRESHOLD=2).
module tb_sc_failmonitor_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] cfail;
  logic [3:0] fail_o;
  logic [2:0] cnt_o;
  logic       total_o;
  logic       armed_o;
`ifdef SC_FAILMONITOR_FIRSTFAIL_EN
  logic [1:0] first_o;
  logic       fvalid_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sc_failmonitor_multi #(
    .NUM_CH(4),
    .IDX_W(2),
    .DEBOUNCE(3),
    .THRESHOLD(2)
  ) dut (
    .SC_FAILMONITOR_CLOCK_50(clk),
    .SC_FAILMONITOR_RESET_InLow(rst_n),
    .SC_FAILMONITOR_Comparador_CFAIL_InLow(cfail),
    .SC_FAILMONITOR_startButton_InLow(start),
    .SC_FAILMONITOR_FAIL_Out(fail_o),
    .SC_FAILMONITOR_FAILCOUNT_Out(cnt_o),
    .SC_FAILMONITOR_TOTAL_FAIL_Out(total_o),
    .SC_FAILMONITOR_ARMED_Out(armed_o)
`ifdef SC_FAILMONITOR_FIRSTFAIL_EN
    ,
    .SC_FAILMONITOR_FIRSTFAIL_Out(first_o),
    .SC_FAILMONITOR_FIRSTVALID_Out(fvalid_o)
`endif
  );

  typedef struct {
    logic [3:0] cfail;
    logic       start;
    logic [3:0] fail;
    logic [2:0] cnt;
    logic       total;
    logic       armed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] c, input logic s, input logic [3:0] f,
                     input logic [2:0] n, input logic t, input logic a);
    vec_t v;
    v.cfail = c; v.start = s; v.fail = f; v.cnt = n; v.total = t; v.armed = a;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] ef, input logic [2:0] ec,
                     input logic et, input logic ea);
    n_cmp++;
    if ({fail_o, cnt_o, total_o, armed_o} !== {ef, ec, et, ea}) begin
      n_err++;
      $display("FAIL %s: got fail=%b cnt=%0d total=%b armed=%b, expected fail=%b cnt=%0d total=%b armed=%b",
               nm, fail_o, cnt_o, total_o, armed_o, ef, ec, et, ea);
    end
  endtask

`ifdef SC_FAILMONITOR_FIRSTFAIL_EN
  task automatic chk_first(input string nm, input logic [1:0] ei, input logic ev);
    n_cmp++;
    if ({first_o, fvalid_o} !== {ei, ev}) begin
      n_err++;
      $display("FAIL %s: got first=%0d valid=%b, expected first=%0d valid=%b",
               nm, first_o, fvalid_o, ei, ev);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // cfail bit order is ch3..ch0
    add(4'b1111, 1, 4'b0000, 3'd0, 0, 0); // edge1 START_0
    add(4'b1111, 1, 4'b0000, 3'd0, 0, 1); // edge2 CHECK_0
    add(4'b1011, 1, 4'b0000, 3'd0, 0, 1); // ch2 low 1
    add(4'b1011, 1, 4'b0000, 3'd0, 0, 1); // ch2 low 2
    add(4'b1111, 1, 4'b0000, 3'd0, 0, 1); // high clears
    add(4'b1011, 1, 4'b0000, 3'd0, 0, 1);
    add(4'b1011, 1, 4'b0000, 3'd0, 0, 1);
    add(4'b1011, 1, 4'b0100, 3'd1, 0, 1); // latch -> FAULT_0
    add(4'b1101, 1, 4'b0100, 3'd1, 0, 1); // ch1 low 1
    add(4'b1101, 1, 4'b0100, 3'd1, 0, 1); // ch1 low 2
    add(4'b1101, 0, 4'b0100, 3'd1, 0, 0); // press wins: INIT_0, ch1 dropped
    add(4'b1101, 0, 4'b0000, 3'd0, 0, 0); // CHECK_1
    add(4'b1111, 0, 4'b0000, 3'd0, 0, 0);
    add(4'b1111, 0, 4'b0000, 3'd0, 0, 0);
    add(4'b1111, 1, 4'b0000, 3'd0, 0, 1); // CHECK_0
    add(4'b1101, 1, 4'b0000, 3'd0, 0, 1); // counter restarted from 0
    add(4'b1101, 1, 4'b0000, 3'd0, 0, 1);
    add(4'b1111, 1, 4'b0000, 3'd0, 0, 1);
    add(4'b0110, 1, 4'b0000, 3'd0, 0, 1); // ch0+ch3 low
    add(4'b0110, 1, 4'b0000, 3'd0, 0, 1);
    add(4'b0110, 1, 4'b1001, 3'd2, 1, 0); // direct CHECK_0 -> TOTAL_0
    for (int i = 0; i < 5; i++) add(4'b1111, 0, 4'b1001, 3'd2, 1, 0);
    add(4'b1111, 1, 4'b1001, 3'd2, 1, 0);
    for (int i = 0; i < 3; i++) add(4'b0000, 1, 4'b1001, 3'd2, 1, 0);

    rst_n = 1'b0;
    cfail = 4'b1111;
    start = 1'b1;
    #2;
    chk("reset_state", 4'b0000, 3'd0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cfail = vecs[i].cfail;
      start = vecs[i].start;
      tick();
      chk($sformatf("vec[%0d]", i), vecs[i].fail, vecs[i].cnt, vecs[i].total, vecs[i].armed);
    end

    // Async reset while in TOTAL_0, no clock edge needed
    #2 rst_n = 1'b0;
    #1 chk("async_rst_total", 4'b0000, 3'd0, 0, 0);
    tick();
    chk("rst_held", 4'b0000, 3'd0, 0, 0);
    #2 rst_n = 1'b1;
    cfail = 4'b1111;
    start = 1'b1;
    tick(); chk("rel_edge1", 4'b0000, 3'd0, 0, 0);
    tick(); chk("rel_edge2", 4'b0000, 3'd0, 0, 1);

    // Async reset mid-debounce, then a fresh 3-edge debounce
    cfail = 4'b1110;
    tick(); chk("db_a1", 4'b0000, 3'd0, 0, 1);
    tick(); chk("db_a2", 4'b0000, 3'd0, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_debounce", 4'b0000, 3'd0, 0, 0);
    tick();
    #2 rst_n = 1'b1;
    tick(); chk("db_rel1", 4'b0000, 3'd0, 0, 0);
    tick(); chk("db_rel2", 4'b0000, 3'd0, 0, 1);
    tick(); chk("db_b1", 4'b0000, 3'd0, 0, 1);
    tick(); chk("db_b2", 4'b0000, 3'd0, 0, 1);
    tick(); chk("db_b3_latch", 4'b0001, 3'd1, 0, 1);

    // Reach threshold via FAULT_0
    cfail = 4'b1101;
    tick(); chk("thr_1", 4'b0001, 3'd1, 0, 1);
    tick(); chk("thr_2", 4'b0001, 3'd1, 0, 1);
    tick(); chk("thr_3_total", 4'b0011, 3'd2, 1, 0);

`ifdef SC_FAILMONITOR_FIRSTFAIL_EN
    #2 rst_n = 1'b0;
    #1 chk_first("ff_reset", 2'd0, 0);
    tick();
    #2 rst_n = 1'b1;
    cfail = 4'b1111;
    tick(); tick();
    cfail = 4'b0111;
    tick(); tick(); tick();
    chk("ff_ch3_latch", 4'b1000, 3'd1, 0, 1);
    chk_first("ff_ch3", 2'd3, 1);
    cfail = 4'b1101;
    tick(); tick(); tick();
    chk("ff_ch1_latch", 4'b1010, 3'd2, 1, 0);
    chk_first("ff_keep3", 2'd3, 1);
    #2 rst_n = 1'b0;
    #1 chk_first("ff_reset2", 2'd0, 0);
    tick();
    #2 rst_n = 1'b1;
    cfail = 4'b1111;
    tick(); tick();
    cfail = 4'b0111;
    tick(); tick(); tick();
    chk_first("ff_ch3_again", 2'd3, 1);
    cfail = 4'b1111;
    start = 1'b0;
    tick(); tick();
    chk_first("ff_init_clear", 2'd0, 0);
    start = 1'b1;
    tick();
    cfail = 4'b1001;
    tick(); tick(); tick();
    chk("ff_dual_latch", 4'b0110, 3'd2, 1, 0);
    chk_first("ff_lowest", 2'd1, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
